// File: rtl/pixel_pkg.sv
// pixel_pkg: shared widths, pixel type and read-out FSM states
package pixel_pkg;
    localparam int PIXEL_W      = 9;
    localparam int BYTE_W       = 8;
    localparam int PIX_PER_WORD = 4;
    localparam int WORD_W       = 32;
    typedef logic [PIXEL_W-1:0] pixel_t;
    typedef enum logic [1:0] {IDLE, SEND, DONE} rd_state_t;
endpackage

// File: rtl/pixel_to_byte.sv
// pixel_to_byte: one 9-bit pixel to one byte; SATURATE_EN clamps instead of truncating
module pixel_to_byte
    import pixel_pkg::*;
(
    input  pixel_t              pix_i,
    output logic [BYTE_W-1:0]   byte_o
);
`ifdef SATURATE_EN
    assign byte_o = pix_i[PIXEL_W-1] ? '1 : pix_i[BYTE_W-1:0];
`else
    logic unused_msb;
    assign unused_msb = pix_i[PIXEL_W-1];
    assign byte_o     = pix_i[BYTE_W-1:0];
`endif
endmodule

// File: rtl/pixel_word_reader.sv
// pixel_word_reader: snapshots a pixel array and streams it as 4-pixel words (SATURATE_EN selects clamping)
module pixel_word_reader
    import pixel_pkg::*;
#(
    parameter int NUM_PIXELS = 160
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                clean,
    input  logic [NUM_PIXELS-1:0][PIXEL_W-1:0]  data_in,
    input  logic                                ready,
    output logic                                valid,
    output logic [WORD_W-1:0]                   data_out,
    output logic [15:0]                         iterator,
    output logic                                busy,
    output logic                                done
);
    localparam int NW     = (NUM_PIXELS + PIX_PER_WORD - 1) / PIX_PER_WORD;
    localparam int WIW    = NW > 1 ? $clog2(NW) : 1;
    localparam int SNAP_W = NW * PIX_PER_WORD * PIXEL_W;
    localparam logic [15:0] LAST = 16'(PIX_PER_WORD * (NW - 1));

    rd_state_t                                  state_q;
    logic [NW*PIX_PER_WORD-1:0][PIXEL_W-1:0]    snap_q;
    logic [15:0]                                iter_q;
    logic                                       valid_q;
    logic                                       done_q;
    logic [WIW-1:0]                             widx;

    // snapshot is padded to whole words with zero pixels, so pad lanes read 0
    assign widx     = iter_q[WIW+1:2];
    assign valid    = valid_q;
    assign busy     = valid_q;
    assign done     = done_q;
    assign iterator = iter_q;

    for (genvar k = 0; k < PIX_PER_WORD; k++) begin : g_lane
        pixel_to_byte u_p2b (
            .pix_i  (snap_q[{widx, 2'(k)}]),
            .byte_o (data_out[k*BYTE_W +: BYTE_W])
        );
    end

    // read-out FSM: capture, step one word per handshake, one-cycle done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            snap_q  <= '0;
            iter_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (clean) begin
            state_q <= IDLE;
            snap_q  <= '0;
            iter_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= SEND;
                    snap_q  <= SNAP_W'(data_in);
                    iter_q  <= '0;
                    valid_q <= 1'b1;
                end
                SEND: if (ready) begin
                    if (iter_q == LAST) begin
                        state_q <= DONE;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        iter_q  <= iter_q + 16'd4;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    iter_q  <= '0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pixel_word_reader.sv
// tb_pixel_word_reader: directed checks of streaming, backpressure, padding, saturation, abort and collisions
module tb_pixel_word_reader;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              clean;
    logic              ready;
    logic              start, start2;
    logic [159:0][8:0] din;
    logic [9:0][8:0]   din2;
    logic              valid, busy, done, valid2, busy2, done2;
    logic [31:0]       dout, dout2;
    logic [15:0]       iter, iter2;
    int                tests = 0;
    int                fails = 0;

    always #5 clk = ~clk;

    pixel_word_reader #(.NUM_PIXELS(160)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clean(clean), .data_in(din), .ready(ready),
        .valid(valid), .data_out(dout), .iterator(iter), .busy(busy), .done(done)
    );

    pixel_word_reader #(.NUM_PIXELS(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start2), .clean(clean), .data_in(din2), .ready(ready),
        .valid(valid2), .data_out(dout2), .iterator(iter2), .busy(busy2), .done(done2)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wexp(int w);
        return {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
    endfunction

    task automatic load_ramp;
        for (int i = 0; i < 160; i++) din[i] = 9'(i);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; clean = 1'b0; ready = 1'b0; start = 1'b0; start2 = 1'b0;
        load_ramp();
        for (int i = 0; i < 10; i++) din2[i] = 9'(i + 1);
        #12;
        tests++; if ({valid, busy, done} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {valid, busy, done}); end
        tests++; if (dout !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 00000000", dout); end
        tests++; if (iter !== 16'h0) begin fails++; $display("FAIL reset_iter got %0d want 0", iter); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 40; w++) begin
            tests++; if (valid !== 1'b1 || busy !== 1'b1) begin fails++; $display("FAIL stream_valid w=%0d got v=%b b=%b want 1 1", w, valid, busy); end
            tests++; if (iter !== 16'(4*w)) begin fails++; $display("FAIL stream_iter w=%0d got %0d want %0d", w, iter, 4*w); end
            tests++; if (dout !== wexp(w)) begin fails++; $display("FAIL stream_data w=%0d got %h want %h", w, dout, wexp(w)); end
            tick();
        end
        tests++; if ({done, busy, valid} !== 3'b100) begin fails++; $display("FAIL stream_done got d/b/v=%b want 100", {done, busy, valid}); end
        start = 1'b1;
        tick();
        tests++; if ({done, valid} !== 2'b00) begin fails++; $display("FAIL start_in_done got d/v=%b want 00", {done, valid}); end
        tick();
        start = 1'b0;
        tests++; if (valid !== 1'b1 || iter !== 16'h0) begin fails++; $display("FAIL restart_after_done got v=%b it=%0d want 1 0", valid, iter); end
        clean = 1'b1;
        tick();
        clean = 1'b0;
    endtask

    task automatic test_backpressure;
        int  expw = 0;
        bit  fin  = 1'b0;
        bit  r;
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            if (done) begin
                fin = 1'b1;
            end else begin
                tests++; if (valid !== 1'b1) begin fails++; $display("FAIL bp_valid c=%0d got %b want 1", c, valid); end
                tests++; if (iter !== 16'(4*expw) || dout !== wexp(expw)) begin fails++; $display("FAIL bp_word c=%0d got it=%0d d=%h want it=%0d d=%h", c, iter, dout, 4*expw, wexp(expw)); end
                r = 1'($urandom_range(0, 1));
                ready = r;
                tick();
                if (r) expw++;
            end
        end
        tests++; if (!fin || expw != 40) begin fails++; $display("FAIL bp_count got fin=%0d words=%0d want 1 40", fin, expw); end
        ready = 1'b1;
        tick();
    endtask

    task automatic test_short;
        logic [31:0] w10 [3];
        w10[0] = 32'h04030201; w10[1] = 32'h08070605; w10[2] = 32'h00000A09;
        ready = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tests++; if (valid2 !== 1'b1 || iter2 !== 16'(4*w) || dout2 !== w10[w]) begin fails++; $display("FAIL short_word w=%0d got v=%b it=%0d d=%h want 1 %0d %h", w, valid2, iter2, dout2, 4*w, w10[w]); end
            tick();
        end
        tests++; if ({done2, valid2} !== 2'b10) begin fails++; $display("FAIL short_done got d/v=%b want 10", {done2, valid2}); end
        tick();
    endtask

    task automatic test_saturate;
        logic [31:0] exp_w;
`ifdef SATURATE_EN
        exp_w = 32'h0302FFFF;
`else
        exp_w = 32'h030200F0;
`endif
        din[0] = 9'h1F0;
        din[1] = 9'h100;
        ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (dout !== exp_w) begin fails++; $display("FAIL saturate got %h want %h", dout, exp_w); end
        clean = 1'b1;
        tick();
        clean = 1'b0;
        load_ramp();
    endtask

    task automatic test_snapshot_abort;
        ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 160; i++) din[i] = 9'h0AA;
        for (int w = 0; w < 5; w++) begin
            tests++; if (dout !== wexp(w)) begin fails++; $display("FAIL snapshot w=%0d got %h want %h", w, dout, wexp(w)); end
            tick();
        end
        tests++; if (iter !== 16'd20) begin fails++; $display("FAIL abort_at5 got it=%0d want 20", iter); end
        clean = 1'b1;
        tick();
        clean = 1'b0;
        tests++; if ({valid, busy, done} !== 3'b000 || iter !== 16'h0) begin fails++; $display("FAIL abort_state got v/b/d=%b it=%0d want 000 0", {valid, busy, done}, iter); end
        tests++; if (dout !== 32'h0) begin fails++; $display("FAIL abort_snap got %h want 00000000", dout); end
        tick();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_nodone got %b want 0", done); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (valid !== 1'b1 || iter !== 16'h0 || dout !== 32'hAAAAAAAA) begin fails++; $display("FAIL restart got v=%b it=%0d d=%h want 1 0 aaaaaaaa", valid, iter, dout); end
    endtask

    task automatic test_collisions;
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (valid !== 1'b1 || iter !== 16'd4) begin fails++; $display("FAIL start_in_send got v=%b it=%0d want 1 4", valid, iter); end
        clean = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        clean = 1'b0;
        tests++; if ({valid, busy} !== 2'b00) begin fails++; $display("FAIL clean_beats_start got v/b=%b want 00", {valid, busy}); end
        tick();
        tests++; if (valid !== 1'b0) begin fails++; $display("FAIL clean_start_idle got v=%b want 0", valid); end
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests++; if (valid !== 1'b1 || iter !== 16'd4) begin fails++; $display("FAIL pre_reset got v=%b it=%0d want 1 4", valid, iter); end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if ({valid, busy, done} !== 3'b000 || iter !== 16'h0 || dout !== 32'h0) begin fails++; $display("FAIL async_reset got v/b/d=%b it=%0d d=%h want 000 0 0", {valid, busy, done}, iter, dout); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_short();
        test_saturate();
        test_snapshot_abort();
        test_collisions();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pixel_word_reader.md
# pixel_word_reader

Read-side counterpart of the pixel byte-packing register: takes a snapshot of a NUM_PIXELS-entry array of 9-bit pixels and streams it out as 32-bit words, four pixels per word, little-endian by pixel index. It sits between the pixel buffer and the HPS-facing bus/FIFO. A valid/ready handshake moves words back to software one per accepted transfer.

## Interface
- NUM_PIXELS, 160, pixel entries in the array; any value ≥1.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request a new read-out; honoured only in IDLE.
- clean  in  1  synchronous abort; returns to IDLE and clears the snapshot.
- data_in  in  [NUM_PIXELS-1:0][8:0]  pixel array to read.
- ready  in  1  downstream accepts data_out this cycle.
- valid  out  1  data_out and iterator hold a word.
- data_out  out  32  bytes [7:0],[15:8],[23:16],[31:24] = pixels iterator, +1, +2, +3.
- iterator  out  16  index of the pixel in data_out[7:0] (multiple of 4).
- busy  out  1  high from snapshot until the last word is accepted.
- done  out  1  one-cycle pulse after the last handshake.

## Operation
- States: IDLE, SEND, DONE.
- IDLE: start=1 and clean=0 → capture data_in into the internal snapshot, iterator←0, go to SEND.
- SEND: valid=1. The word is built combinationally from the snapshot at iterator.
  - A handshake is valid&ready.
  - On a handshake that is not the last word: iterator += 4.
  - On the last word's handshake: go to DONE.
- Last word: iterator = 4*(ceil(NUM_PIXELS/4)-1).
- Byte lanes whose pixel index is ≥ NUM_PIXELS read as 8'h00.
- DONE: done=1 and busy=0 for one cycle, then go to IDLE with iterator←0.
- start is ignored in SEND and DONE. The snapshot makes the stream immune to data_in changes after capture.
- clean in any state → IDLE next cycle, valid=0, snapshot and iterator cleared, no done pulse.
- clean beats start in the same cycle. clean beats a handshake in the same cycle; that word counts as not delivered.
- Pixel-to-byte conversion depends on the macro; see Configuration.

## Timing
- Reset values: valid=0, data_out=0, iterator=0, busy=0, done=0, state IDLE, snapshot all zero.
- Start accepted in cycle N → busy=1 and valid=1 with word 0 in cycle N+1.
- Throughput: one word per cycle while ready is held high.
- Total time for W words with ready held high: start → done takes W+1 cycles.
- While valid=1 and ready=0, data_out and iterator are held stable.
- valid is never dropped without a handshake, except by clean or reset.
- A new start can be accepted in the cycle after done at the earliest.
- Reset asserted mid-stream: all outputs return to reset values immediately (asynchronous).

## Configuration
- SATURATE_EN defined: each lane = (pixel > 255) ? 8'hFF : pixel[7:0].
- SATURATE_EN undefined: each lane = pixel[7:0]; bit 8 is discarded. This is the truncation the write path's inverse implies.

## Structure
- Package pixel_pkg holds:
  - PIXEL_W=9, BYTE_W=8, PIX_PER_WORD=4, WORD_W=32;
  - typedef pixel_t;
  - the enum rd_state_t {IDLE, SEND, DONE}.
- Sub-module pixel_to_byte converts one 9-bit pixel to 8 bits under SATURATE_EN. It is instantiated four times, once per lane.

## Test plan
- NUM_PIXELS=160, pixel[i]=i, ready=1, start pulse:
  - 40 words, first 32'h03020100, last 32'h9F9E9D9C;
  - iterator steps 0..156 by 4;
  - done pulse 41 cycles after start.
- Backpressure: ready toggles randomly. data_out and iterator stay stable across every stall, with no word dropped or duplicated.
- NUM_PIXELS=10, pixel[i]=i+1:
  - 3 words;
  - last word is 32'h00000A09, with the pad lanes zero.
- Pixel value 9'h1F0:
  - byte 8'hFF with SATURATE_EN defined;
  - byte 8'hF0 without it.
- Snapshot and abort:
  - change data_in after start → stream still shows the captured values;
  - clean during word 5 → valid=0 next cycle, iterator=0, no done;
  - a following start streams from word 0.
- Collisions:
  - start during SEND is ignored;
  - start together with clean in IDLE leaves the block in IDLE;
  - rst_n asserted mid-stream zeroes all outputs asynchronously.
